// File: rtl/sdram_read.sv
// SDRAM read engine: ACTIVE, READ, BURST STOP and PRECHARGE-all for one
// full-page burst, with CAS-latency-aligned capture of the returning DQ words.
module sdram_read #(
  parameter int TRCD_CLK = 2,
  parameter int TRP_CLK  = 2,
  parameter int CAS_LAT  = 3
) (
  input  logic        rd_clk,
  input  logic        rd_rst_n,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_bst_len,
  input  logic        init_end,
  input  logic [15:0] rd_sdram_dq,
  output logic        rd_ack,
  output logic        rd_end,
  output logic [3:0]  rd_sdram_cmd,
  output logic [1:0]  rd_sdram_bank,
  output logic [12:0] rd_sdram_addr,
  output logic        rd_sdram_en,
  output logic [15:0] rd_sdram_data
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK - 1);
  localparam logic [9:0] TRP_LAST  = 10'(TRP_CLK - 1);
  localparam logic [9:0] CAS_W     = 10'(CAS_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_TRCD, S_RD, S_DATA, S_PRE, S_TRP, S_END
  } state_t;

  state_t      state_curr;
  state_t      state_next;
  logic [9:0]  cnt;
  logic [1:0]  bank_q;
  logic [12:0] row_q;
  logic [8:0]  col_q;
  logic [9:0]  len_q;
  logic [9:0]  data_last;
  logic [9:0]  bst_cnt;
  logic        capture;

  // The last DATA count is where the final word sits on DQ.
  assign data_last = len_q + CAS_W - 10'd1;
  assign bst_cnt   = len_q - 10'd1;
  assign capture   = (state_curr == S_DATA) && (cnt >= CAS_W);
  assign rd_end    = (state_curr == S_END);

  always_comb begin
    state_next = state_curr;
    case (state_curr)
      S_IDLE: if (init_end && rd_en) state_next = S_ACT;
      S_ACT:  state_next = S_TRCD;
      S_TRCD: if (cnt == TRCD_LAST) state_next = S_RD;
      S_RD:   state_next = S_DATA;
      S_DATA: if (cnt == data_last) state_next = S_PRE;
      S_PRE:  state_next = S_TRP;
      S_TRP:  if (cnt == TRP_LAST) state_next = S_END;
      S_END:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the current state, so every command
  // lands on the bus one cycle after the state that issues it.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_curr    <= S_IDLE;
      cnt           <= 10'd0;
      bank_q        <= 2'd0;
      row_q         <= 13'd0;
      col_q         <= 9'd0;
      len_q         <= 10'd1;
      rd_sdram_cmd  <= CMD_NOP;
      rd_sdram_bank <= 2'b11;
      rd_sdram_addr <= 13'h1fff;
      rd_ack        <= 1'b0;
      rd_sdram_en   <= 1'b0;
      rd_sdram_data <= 16'h0000;
    end else begin
      state_curr <= state_next;
      if (state_next != state_curr || state_curr == S_IDLE)
        cnt <= 10'd0;
      else
        cnt <= cnt + 10'd1;

      if (state_curr == S_IDLE && state_next == S_ACT) begin
        bank_q <= rd_addr[23:22];
        row_q  <= rd_addr[21:9];
        col_q  <= rd_addr[8:0];
        len_q  <= (rd_bst_len == 10'd0) ? 10'd1 : rd_bst_len;
      end

      rd_sdram_en <= (state_next != S_IDLE);

      rd_sdram_cmd  <= CMD_NOP;
      rd_sdram_bank <= 2'b11;
      rd_sdram_addr <= 13'h1fff;
      case (state_curr)
        S_ACT: begin
          rd_sdram_cmd  <= CMD_ACT;
          rd_sdram_bank <= bank_q;
          rd_sdram_addr <= row_q;
        end
        S_RD: begin
          rd_sdram_cmd  <= CMD_RD;
          rd_sdram_bank <= bank_q;
          rd_sdram_addr <= {4'b0000, col_q};
        end
        S_DATA: begin
          if (cnt == bst_cnt) rd_sdram_cmd <= CMD_BST;
        end
        S_PRE: begin
          rd_sdram_cmd  <= CMD_PRE;
          rd_sdram_bank <= bank_q;
          rd_sdram_addr <= 13'h0400;
        end
        default: ;
      endcase

      rd_ack <= capture;
      if (capture) rd_sdram_data <= rd_sdram_dq;
    end
  end

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read: two instances (CAS 3 and CAS 2) share the
// request inputs; each has a small DQ model keyed off the READ on its bus.
module tb_sdram_read;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n;
  logic        rd_en = 1'b0;
  logic        init_end = 1'b0;
  logic [23:0] rd_addr = 24'd0;
  logic [9:0]  rd_bst_len = 10'd0;
  logic [15:0] dqA = 16'd0;
  logic [15:0] dqB = 16'd0;

  logic        ackA, endA, enA, ackB, endB, enB;
  logic [3:0]  cmdA, cmdB;
  logic [1:0]  bankA, bankB;
  logic [12:0] addrA, addrB;
  logic [15:0] dataA, dataB;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int rdCycA = -1000;
  int rdCycB = -1000;
  int kA, kB;
  int modelLen = 1;
  logic [15:0] base = 16'd0;
  logic sel = 1'b0;

  logic        obsAck, obsEnd, obsEn;
  logic [3:0]  obsCmd;
  logic [1:0]  obsBank;
  logic [12:0] obsAddr;
  logic [15:0] obsData;

  assign obsAck  = sel ? ackB  : ackA;
  assign obsEnd  = sel ? endB  : endA;
  assign obsEn   = sel ? enB   : enA;
  assign obsCmd  = sel ? cmdB  : cmdA;
  assign obsBank = sel ? bankB : bankA;
  assign obsAddr = sel ? addrB : addrA;
  assign obsData = sel ? dataB : dataA;

  always #5 rd_clk = ~rd_clk;

  sdram_read #(.TRCD_CLK(2), .TRP_CLK(2), .CAS_LAT(3)) dutA (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_bst_len(rd_bst_len), .init_end(init_end), .rd_sdram_dq(dqA),
    .rd_ack(ackA), .rd_end(endA), .rd_sdram_cmd(cmdA), .rd_sdram_bank(bankA),
    .rd_sdram_addr(addrA), .rd_sdram_en(enA), .rd_sdram_data(dataA)
  );

  sdram_read #(.TRCD_CLK(2), .TRP_CLK(2), .CAS_LAT(2)) dutB (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_bst_len(rd_bst_len), .init_end(init_end), .rd_sdram_dq(dqB),
    .rd_ack(ackB), .rd_end(endB), .rd_sdram_cmd(cmdB), .rd_sdram_bank(bankB),
    .rd_sdram_addr(addrB), .rd_sdram_en(enB), .rd_sdram_data(dataB)
  );

  always @(posedge rd_clk) cyc <= cyc + 1;

  // Word k is driven CAS_LAT+k cycles after READ is seen on the bus;
  // everything else is junk so a misplaced capture window shows up.
  always @(negedge rd_clk) begin
    if (cmdA == CMD_RD) rdCycA = cyc;
    if (cmdB == CMD_RD) rdCycB = cyc;
    kA = cyc - rdCycA - 3;
    kB = cyc - rdCycB - 2;
    dqA = (kA >= 0 && kA < modelLen) ? base + 16'(kA) : 16'hDEAD;
    dqB = (kB >= 0 && kB < modelLen) ? base + 16'(kB) : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_cmd"},  32'(obsCmd),  32'(CMD_NOP));
    check({tag, "_bank"}, 32'(obsBank), 32'(2'b11));
    check({tag, "_addr"}, 32'(obsAddr), 32'(13'h1fff));
    check({tag, "_en"},   32'(obsEn),   32'd0);
    check({tag, "_ack"},  32'(obsAck),  32'd0);
    check({tag, "_end"},  32'(obsEnd),  32'd0);
  endtask

  task automatic waitAct(input int bound);
    int n = 0;
    do begin
      step();
      n++;
    end while (obsCmd != CMD_ACT && n < bound);
    check("act_seen", 32'(obsCmd == CMD_ACT), 32'd1);
  endtask

  // Entered on the cycle ACT is on the bus; checks every bus cycle up to the
  // first IDLE cycle after END.
  task automatic checkBurst(input logic [23:0] a, input int len, input int cas,
                            input logic [15:0] b, input bit holdEn);
    int r, p, e;
    logic [3:0]  eCmd;
    logic [1:0]  eBank;
    logic [12:0] eAddr;
    logic        eAck;
    r = 3;
    p = r + cas + len + 1;
    e = p + 2;
    if (!holdEn) begin
      rd_en = 1'b0;
      rd_addr = 24'hFFFFFF;
      rd_bst_len = 10'd7;
    end
    for (int i = 0; i <= e + 1; i++) begin
      if (i > 0) step();
      eCmd = CMD_NOP; eBank = 2'b11; eAddr = 13'h1fff;
      if (i == 0) begin eCmd = CMD_ACT; eBank = a[23:22]; eAddr = a[21:9]; end
      else if (i == r) begin eCmd = CMD_RD; eBank = a[23:22]; eAddr = {4'b0000, a[8:0]}; end
      else if (i == r + len) eCmd = CMD_BST;
      else if (i == p) begin eCmd = CMD_PRE; eBank = a[23:22]; eAddr = 13'h0400; end
      eAck = (i >= r + cas + 1) && (i <= r + cas + len);
      check($sformatf("cmd@%0d", i),  32'(obsCmd),  32'(eCmd));
      check($sformatf("bank@%0d", i), 32'(obsBank), 32'(eBank));
      check($sformatf("addr@%0d", i), 32'(obsAddr), 32'(eAddr));
      check($sformatf("ack@%0d", i),  32'(obsAck),  32'(eAck));
      check($sformatf("end@%0d", i),  32'(obsEnd),  32'(i == e));
      check($sformatf("en@%0d", i),   32'(obsEn),   32'(i <= e));
      if (eAck)
        check($sformatf("data@%0d", i), 32'(obsData), 32'(b + 16'(i - r - cas - 1)));
      else if (i > r + cas + len)
        check($sformatf("hold@%0d", i), 32'(obsData), 32'(b + 16'(len - 1)));
    end
  endtask

  initial begin
    rd_rst_n = 1'b1;
    #2 rd_rst_n = 1'b0;
    step();
    check("rst_data", 32'(dataA), 32'd0);
    checkIdle("rst");
    @(negedge rd_clk) rd_rst_n = 1'b1;

    // Requests are blocked while init_end is low.
    rd_en = 1'b1;
    rd_addr = 24'h5A3C07;
    rd_bst_len = 10'd4;
    for (int i = 0; i < 20; i++) begin
      step();
      checkIdle("noinit");
    end

    // len 4, CAS 3: bank 01, row 0x0D1E, col 0x007.
    base = 16'hA000; modelLen = 4;
    init_end = 1'b1;
    waitAct(10);
    checkBurst(24'h5A3C07, 4, 3, 16'hA000, 1'b0);
    repeat (10) step();

    // Single-word burst.
    rd_addr = 24'h800205; rd_bst_len = 10'd1; base = 16'h1234; modelLen = 1;
    rd_en = 1'b1;
    waitAct(10);
    checkBurst(24'h800205, 1, 3, 16'h1234, 1'b0);
    repeat (10) step();

    // Zero length behaves as a single word.
    rd_addr = 24'h3FFE00; rd_bst_len = 10'd0; base = 16'h0BEE; modelLen = 1;
    rd_en = 1'b1;
    waitAct(10);
    checkBurst(24'h3FFE00, 1, 3, 16'h0BEE, 1'b0);
    repeat (10) step();

    // Full page on the CAS 2 instance.
    sel = 1'b1;
    rd_addr = 24'hC0A1FF; rd_bst_len = 10'd512; base = 16'h2000; modelLen = 512;
    rd_en = 1'b1;
    waitAct(10);
    checkBurst(24'hC0A1FF, 512, 2, 16'h2000, 1'b0);
    sel = 1'b0;
    repeat (10) step();

    // Back-to-back: rd_en held through END gives one IDLE cycle, then ACT.
    rd_addr = 24'h123456; rd_bst_len = 10'd3; base = 16'h3000; modelLen = 3;
    rd_en = 1'b1;
    waitAct(10);
    checkBurst(24'h123456, 3, 3, 16'h3000, 1'b1);
    rd_addr = 24'hC10010; rd_bst_len = 10'd2; base = 16'h4000; modelLen = 2;
    step();
    check("b2b_act_en", 32'(enA), 32'd1);
    check("b2b_act_cmd", 32'(cmdA), 32'(CMD_NOP));
    step();
    check("b2b_act_bus", 32'(cmdA), 32'(CMD_ACT));
    checkBurst(24'hC10010, 2, 3, 16'h4000, 1'b0);
    repeat (20) step();

    // Reset three cycles into DATA aborts the burst without rd_end.
    rd_addr = 24'h400100; rd_bst_len = 10'd8; base = 16'h6000; modelLen = 8;
    rd_en = 1'b1;
    waitAct(10);
    rd_en = 1'b0;
    repeat (6) step();
    rd_rst_n = 1'b0;
    #1;
    check("abort_data", 32'(dataA), 32'd0);
    checkIdle("abort");
    step();
    checkIdle("abort_hold");
    @(negedge rd_clk) rd_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checkIdle("post_abort");
    end

    rd_addr = 24'h7FFFFF; rd_bst_len = 10'd5; base = 16'h5000; modelLen = 5;
    rd_en = 1'b1;
    waitAct(10);
    checkBurst(24'h7FFFFF, 5, 3, 16'h5000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
